// File: rtl/wb_uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_uart_rx_pkg
//  Description : Shared SoC definitions for the Wishbone UART receiver:
//                register offsets, register bit positions and the
//                receive FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_uart_rx_pkg;

    // Register offsets as seen on wb_addr_i[3:2]
    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_LEVEL  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // RXDATA fields
    localparam int unsigned RXDATA_VALID_BIT = 8;

    // STATUS bit positions
    localparam int unsigned STATUS_NOT_EMPTY_BIT = 0;
    localparam int unsigned STATUS_FULL_BIT      = 1;
    localparam int unsigned STATUS_OVERRUN_BIT   = 2;
    localparam int unsigned STATUS_FRAME_ERR_BIT = 3;

    // CTRL bit positions
    localparam int unsigned CTRL_IRQ_EN_BIT = 0;

    // Receive FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

endpackage : wb_uart_rx_pkg
`default_nettype wire

// File: rtl/wb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : Serial receive engine: 2-flop input synchronizer, start-bit
//                validation, 8N1 bit sampling. Emits a received byte with a
//                one-cycle valid strobe, or a one-cycle frame-error strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import wb_uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
    // Start bit is checked half a bit in; data/stop samples one full bit apart
    localparam logic [TIMER_W-1:0] HALF_M1 = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_M1 = TIMER_W'(CLKS_PER_BIT - 1);

    logic [1:0]         sync_q;
    logic               prev_q;
    logic               w_rx;
    logic               w_fall;
    rx_state_t          state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;

    assign w_rx   = sync_q[1];
    assign w_fall = prev_q & ~w_rx;

    // Bring the asynchronous line into the clock domain; idle level is high
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            prev_q <= w_rx;
        end
    end

    // Frame FSM with bit timer; outputs are registered strobes
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    timer_q   <= '0;
                    bit_idx_q <= '0;
                    if (w_fall) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (timer_q == HALF_M1) begin
                        timer_q <= '0;
                        // A line already back high mid start bit was only a glitch
                        state_q <= w_rx ? S_IDLE : S_DATA;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                S_DATA: begin
                    if (timer_q == FULL_M1) begin
                        timer_q <= '0;
                        shift_q <= {w_rx, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                S_STOP: begin
                    if (timer_q == FULL_M1) begin
                        timer_q <= '0;
                        state_q <= S_IDLE;
                        if (w_rx) begin
                            byte_o  <= shift_q;
                            valid_o <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule : uart_rx_core
`default_nettype wire

// File: rtl/wb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : wb_uart_rx
//  Description : Wishbone-attached UART receiver with RX FIFO, sticky
//                overrun / frame-error status and a level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_uart_rx
    import wb_uart_rx_pkg::*;
#(
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    input  logic                     uart_rx_i,
    output logic                     rx_irq_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]               core_byte;
    logic                     core_valid;
    logic                     core_ferr;

    logic [7:0]               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic                     overrun_q;
    logic                     frame_err_q;
    logic                     irq_en_q;

    logic                     w_req;
    logic                     w_rd;
    logic                     w_wr;
    logic [1:0]               w_reg;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_ovr_set;
    logic                     w_w1c_ovr;
    logic                     w_w1c_ferr;
    logic [WB_DATA_WIDTH-1:0] w_rdata;
    logic                     w_unused;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .rx_i        (uart_rx_i),
        .byte_o      (core_byte),
        .valid_o     (core_valid),
        .frame_err_o (core_ferr)
    );

    // Only the register index, byte lane 0 and the low data byte are decoded
    assign w_unused = ^{wb_addr_i, wb_data_i, wb_sel_i};

    assign w_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign w_rd    = w_req & ~wb_we_i;
    assign w_wr    = w_req &  wb_we_i;
    assign w_reg   = wb_addr_i[3:2];
    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == CNT_W'(FIFO_DEPTH));

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_pop     = w_rd & (w_reg == REG_RXDATA) & ~w_empty;
    assign w_push    = core_valid & (~w_full | w_pop);
    assign w_ovr_set = core_valid & w_full & ~w_pop;

    assign w_w1c_ovr  = w_wr & (w_reg == REG_STATUS) & wb_sel_i[0] & wb_data_i[STATUS_OVERRUN_BIT];
    assign w_w1c_ferr = w_wr & (w_reg == REG_STATUS) & wb_sel_i[0] & wb_data_i[STATUS_FRAME_ERR_BIT];

    // Read-data mux; unused bits stay zero
    always_comb begin
        w_rdata = '0;
        unique case (w_reg)
            REG_RXDATA: begin
                if (!w_empty) begin
                    w_rdata[7:0]             = mem_q[rd_ptr_q];
                    w_rdata[RXDATA_VALID_BIT] = 1'b1;
                end
            end
            REG_STATUS: begin
                w_rdata[STATUS_NOT_EMPTY_BIT] = ~w_empty;
                w_rdata[STATUS_FULL_BIT]      = w_full;
                w_rdata[STATUS_OVERRUN_BIT]   = overrun_q;
                w_rdata[STATUS_FRAME_ERR_BIT] = frame_err_q;
            end
            REG_LEVEL: w_rdata[CNT_W-1:0] = count_q;
            default:   w_rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
        endcase
    end

    // FIFO storage has no reset; validity is governed by the pointers
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= core_byte;
        end
    end

    // FIFO pointers, occupancy, status and control registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_en_q    <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                count_q <= count_q - CNT_W'(1);
            end
            // A new error event wins over a simultaneous clear
            overrun_q   <= (overrun_q   & ~w_w1c_ovr)  | w_ovr_set;
            frame_err_q <= (frame_err_q & ~w_w1c_ferr) | core_ferr;
            if (w_wr && (w_reg == REG_CTRL) && wb_sel_i[0]) begin
                irq_en_q <= wb_data_i[CTRL_IRQ_EN_BIT];
            end
        end
    end

    // Wishbone response and level interrupt, both registered
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_ack_o  <= 1'b0;
            wb_data_o <= '0;
            rx_irq_o  <= 1'b0;
        end else begin
            wb_ack_o  <= w_req;
            wb_data_o <= w_rd ? w_rdata : '0;
            rx_irq_o  <= irq_en_q & (~w_empty | overrun_q | frame_err_q);
        end
    end

endmodule : wb_uart_rx
`default_nettype wire

// File: tb/tb_wb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_uart_rx
//  Description : Self-checking bench for wb_uart_rx. A queue-based model of
//                the receive FIFO and status bits predicts every register read.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam logic [1:0] A_RXDATA = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_LEVEL  = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = 4'hF;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        ack;
    logic [31:0] rdat;
    logic        rx = 1'b1;
    logic        irq;

    int unsigned cyc_cnt = 0;
    int unsigned start_edge = 0;
    int unsigned push_off = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model
    logic [7:0]  mq[$];
    bit          m_ovr = 1'b0;
    bit          m_ferr = 1'b0;
    bit          m_irq_en = 1'b0;

    wb_uart_rx #(
        .WB_DATA_WIDTH (32),
        .WB_ADDR_WIDTH (32),
        .CLKS_PER_BIT  (CPB),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .wb_addr_i (adr),
        .wb_data_i (wdat),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_ack_o  (ack),
        .wb_data_o (rdat),
        .uart_rx_i (rx),
        .rx_irq_o  (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- model helpers ----------------
    function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)             m_ferr = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else                      m_ovr = 1'b1;
    endfunction

    function automatic logic [31:0] model_status();
        return {28'd0, m_ferr, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
    endfunction

    function automatic logic [31:0] model_pop();
        if (mq.size() == 0) return 32'd0;
        return {23'd0, 1'b1, mq.pop_front()};
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovr = 1'b0; m_ferr = 1'b0; m_irq_en = 1'b0;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic uart_send(input logic [7:0] b, input bit stop_ok);
        @(posedge clk); #1;
        start_edge = cyc_cnt;
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop_ok;
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic wb_read(input logic [1:0] r, output logic [31:0] d);
        int k;
        @(posedge clk); #1;
        adr = {28'd0, r, 2'b00}; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        d = 32'hDEAD_BEEF;
        for (k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ack) begin
                d = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        if (k == 8) begin
            n_vec++; n_err++;
            $display("FAIL wb_read_ack: no ack for reg %0d, required ack within 8 cycles", r);
        end
    endtask

    task automatic wb_write(input logic [1:0] r, input logic [31:0] v);
        int k;
        @(posedge clk); #1;
        adr = {28'd0, r, 2'b00}; wdat = v; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        for (k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ack) break;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (k == 8) begin
            n_vec++; n_err++;
            $display("FAIL wb_write_ack: no ack for reg %0d, required ack within 8 cycles", r);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({ack, irq, rdat} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_outputs: ack=%b irq=%b data=%h required 0/0/0", ack, irq, rdat);
        end
        rst_n = 1'b1;
        model_reset();
        for (int r = 0; r < 4; r++) begin
            wb_read(2'(r), d);
            n_vec++;
            if (d !== 32'd0) begin
                n_err++;
                $display("FAIL reset_reg%0d: got %h required 00000000", r, d);
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] d, e;
        uart_send(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1);
        wb_read(A_LEVEL, d);  e = mq.size();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL single_level: got %h required %h", d, e); end
        wb_read(A_STATUS, d); e = model_status();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL single_status: got %h required %h", d, e); end
        wb_read(A_RXDATA, d); e = model_pop();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL single_rxdata: got %h required %h", d, e); end
        wb_read(A_LEVEL, d);  e = mq.size();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL single_level_after: got %h required %h", d, e); end
    endtask

    task automatic test_frame_err();
        logic [31:0] d, e;
        uart_send(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        wb_read(A_STATUS, d); e = model_status();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL ferr_status: got %h required %h", d, e); end
        wb_read(A_LEVEL, d);  e = mq.size();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL ferr_level: got %h required %h", d, e); end
        wb_write(A_STATUS, 32'h8);
        m_ferr = 1'b0;
        wb_read(A_STATUS, d); e = model_status();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL ferr_clear: got %h required %h", d, e); end
    endtask

    task automatic test_glitch();
        logic [31:0] d, e;
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        wb_read(A_LEVEL, d);  e = mq.size();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL glitch_level: got %h required %h", d, e); end
        wb_read(A_STATUS, d); e = model_status();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL glitch_status: got %h required %h", d, e); end
        // Receiver must be back in idle and catch the next frame cleanly
        uart_send(8'h96, 1'b1);
        model_frame(8'h96, 1'b1);
        wb_read(A_RXDATA, d); e = model_pop();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL glitch_next_byte: got %h required %h", d, e); end
    endtask

    task automatic test_overrun();
        logic [31:0] d, e;
        for (int i = 0; i <= 16; i++) begin
            uart_send(8'(i), 1'b1);
            model_frame(8'(i), 1'b1);
        end
        wb_read(A_STATUS, d); e = model_status();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL ovr_status: got %h required %h", d, e); end
        wb_read(A_LEVEL, d);  e = mq.size();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL ovr_level: got %h required %h", d, e); end
        for (int i = 0; i <= 16; i++) begin
            wb_read(A_RXDATA, d); e = model_pop();
            n_vec++; if (d !== e) begin n_err++; $display("FAIL ovr_read%0d: got %h required %h", i, d, e); end
        end
        wb_write(A_STATUS, 32'h4);
        m_ovr = 1'b0;
        wb_read(A_STATUS, d); e = model_status();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL ovr_clear: got %h required %h", d, e); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d, e;
        int unsigned irq_edge;
        // Start a frame of zeros and reset in the middle of data bit 3
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (CPB + 3 * CPB + CPB / 2) @(posedge clk);
        #1;
        rst_n = 1'b0; rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (2 * CPB) @(posedge clk);
        wb_read(A_LEVEL, d);  e = mq.size();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL rstmid_level: got %h required %h", d, e); end
        wb_read(A_STATUS, d); e = model_status();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL rstmid_status: got %h required %h", d, e); end
        wb_write(A_CTRL, 32'h1);
        m_irq_en = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_idle: got %b required 0", irq); end
        irq_edge = 0;
        fork
            uart_send(8'h5A, 1'b1);
            begin
                for (int k = 0; k < 11 * CPB; k++) begin
                    @(posedge clk); #1;
                    if (irq && irq_edge == 0) irq_edge = cyc_cnt;
                end
            end
        join
        model_frame(8'h5A, 1'b1);
        n_vec++;
        if (irq_edge == 0) begin
            n_err++;
            $display("FAIL irq_rise: rx_irq_o=0 after frame, required 1");
            push_off = 10 * CPB - 4;
        end else begin
            push_off = irq_edge - 1 - start_edge;
        end
        wb_read(A_LEVEL, d);  e = mq.size();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL rstmid_level2: got %h required %h", d, e); end
        for (int i = 0; i < 2; i++) begin
            wb_read(A_RXDATA, d); e = model_pop();
            n_vec++; if (d !== e) begin n_err++; $display("FAIL rstmid_rx%0d: got %h required %h", i, d, e); end
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_fall: got %b required 0", irq); end
    endtask

    task automatic test_full_simultaneous();
        logic [31:0] d, e, got;
        logic [7:0]  b;
        got = 32'hDEAD_BEEF;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            uart_send(b, 1'b1);
            model_frame(b, 1'b1);
        end
        wb_read(A_LEVEL, d); e = mq.size();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL full_level: got %h required %h", d, e); end
        b = 8'($urandom);
        fork
            uart_send(b, 1'b1);
            begin
                int unsigned tgt;
                @(posedge clk); #2;
                tgt = start_edge + push_off - 1;
                while (cyc_cnt < tgt) begin
                    @(posedge clk); #1;
                end
                adr = {28'd0, A_RXDATA, 2'b00}; we = 1'b0; cyc = 1'b1; stb = 1'b1;
                @(posedge clk); #1;
                if (ack) got = rdat;
                cyc = 1'b0; stb = 1'b0;
            end
        join
        e = model_pop();
        mq.push_back(b);
        n_vec++; if (got !== e) begin n_err++; $display("FAIL simul_rxdata: got %h required %h", got, e); end
        wb_read(A_LEVEL, d); e = mq.size();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL simul_level: got %h required %h", d, e); end
        wb_read(A_STATUS, d); e = model_status();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL simul_status: got %h required %h", d, e); end
        for (int i = 0; i < DEPTH; i++) begin
            wb_read(A_RXDATA, d); e = model_pop();
            n_vec++; if (d !== e) begin n_err++; $display("FAIL simul_drain%0d: got %h required %h", i, d, e); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        logic [7:0]  b;
        bit          ok;
        for (int i = 0; i < 12; i++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(5) != 0);
            uart_send(b, ok);
            model_frame(b, ok);
            repeat ($urandom_range(CPB)) @(posedge clk);
        end
        wb_write(A_LEVEL, 32'hFF);
        wb_write(A_RXDATA, 32'h1FF);
        wb_read(A_LEVEL, d);  e = mq.size();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL rand_level: got %h required %h", d, e); end
        wb_read(A_STATUS, d); e = model_status();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL rand_status: got %h required %h", d, e); end
        wb_read(A_CTRL, d);   e = {31'd0, m_irq_en};
        n_vec++; if (d !== e) begin n_err++; $display("FAIL rand_ctrl: got %h required %h", d, e); end
        n_vec++;
        if (irq !== (m_irq_en & ((mq.size() != 0) | m_ovr | m_ferr))) begin
            n_err++;
            $display("FAIL rand_irq: got %b required %b", irq, m_irq_en & ((mq.size() != 0) | m_ovr | m_ferr));
        end
        for (int i = 0; i < 13; i++) begin
            wb_read(A_RXDATA, d); e = model_pop();
            n_vec++; if (d !== e) begin n_err++; $display("FAIL rand_read%0d: got %h required %h", i, d, e); end
        end
        wb_write(A_STATUS, 32'hC);
        m_ovr = 1'b0; m_ferr = 1'b0;
        wb_read(A_STATUS, d); e = model_status();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL rand_clear: got %h required %h", d, e); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_reset_midframe();
        test_full_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_uart_rx
`default_nettype wire
